ahb_slave_addr_decoder: RTL and testbench

AHB_SLAVE_ADDR_DECODER -- requirements
Module: ahb_slave_addr_decoder

---
 rtl/ahb_slave_addr_decoder.sv | 230 +++++++++++++++++++++++
 tb/tb_ahb_slave_addr_decoder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_addr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ahb_slave_addr_decoder
// Description : AHB-Lite slave address decoder for a small 16-byte register
//               map. Accepted address-phase signals are decoded and
//               registered, so the dec_* outputs describe the transfer in its
//               data phase, one cycle after acceptance. Illegal transfers get
//               the two-cycle AHB ERROR response and produce no decode.
//
//               Map (byte addresses):
//                 0x0-0x3 BUFFER  (RW)   0x4-0x5 STATUS (RO)
//                 0x6-0x7 ERROR   (RO)   0x8     OCCUP  (RO, RW if OCC_WRITABLE)
//                 0xC     TX_CTRL (RW)   0xD     FLUSH  (RW)
//
// Ports       : clk, n_rst (async, active-low)
//               hsel, htrans[1:0], haddr[ADDR_W-1:0], hsize[HSIZE_W-1:0],
//               hwrite                          - AHB address phase in
//               hready, hresp                   - HREADYOUT / HRESP out
//               dec_valid, dec_write, dec_region[2:0], dec_byte_en[3:0]
//                                               - registered decode result
//
// Options     : define ADDR_DECODER_ALIGN_CHECK_EN to also reject misaligned
//               halfword/word transfers with an ERROR response.
//
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_slave_addr_decoder #(
    parameter int ADDR_W       = 4,
    parameter int HSIZE_W      = 3,
    parameter int OCC_WRITABLE = 0
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               hsel,
    input  logic [1:0]         htrans,
    input  logic [ADDR_W-1:0]  haddr,
    input  logic [HSIZE_W-1:0] hsize,
    input  logic               hwrite,
    output logic               hready,
    output logic               hresp,
    output logic               dec_valid,
    output logic               dec_write,
    output logic [2:0]         dec_region,
    output logic [3:0]         dec_byte_en
);

    localparam logic [2:0] c_rgn_buffer  = 3'd0;
    localparam logic [2:0] c_rgn_status  = 3'd1;
    localparam logic [2:0] c_rgn_error   = 3'd2;
    localparam logic [2:0] c_rgn_occup   = 3'd3;
    localparam logic [2:0] c_rgn_tx_ctrl = 3'd4;
    localparam logic [2:0] c_rgn_flush   = 3'd5;
    localparam logic [2:0] c_rgn_none    = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_t;

    state_t     r_state;
    logic       r_hready;
    logic       r_hresp;

    logic       w_accept;
    logic       w_err;
    logic       w_mapped;
    logic       w_ro;
    logic       w_size_bad;
    logic       w_overrun;
    logic       w_misalign;
    logic [2:0] w_region;
    logic [1:0] w_base_lo;   // region base, low two bits (offsets never exceed 3)
    logic [2:0] w_rgn_size;  // region length in bytes
    logic [2:0] w_nbytes;
    logic [3:0] w_mask;
    logic [1:0] w_off;
    logic [3:0] w_end;
    logic [3:0] w_byte_en;

    assign hready   = r_hready;
    assign hresp    = r_hresp;

    // hready is low only in ERR1, so nothing is accepted there.
    assign w_accept = hsel & htrans[1] & r_hready;

    // ------------------------------------------------------------------
    // Address-phase decode
    // ------------------------------------------------------------------
    always_comb begin
        w_mapped   = 1'b1;
        w_ro       = 1'b0;
        w_region   = c_rgn_none;
        w_base_lo  = 2'd0;
        w_rgn_size = 3'd1;
        case (haddr[3:0])
            4'h0, 4'h1, 4'h2, 4'h3: begin
                w_region   = c_rgn_buffer;
                w_rgn_size = 3'd4;
            end
            4'h4, 4'h5: begin
                w_region   = c_rgn_status;
                w_rgn_size = 3'd2;
                w_ro       = 1'b1;
            end
            4'h6, 4'h7: begin
                w_region   = c_rgn_error;
                w_base_lo  = 2'd2;
                w_rgn_size = 3'd2;
                w_ro       = 1'b1;
            end
            4'h8: begin
                w_region   = c_rgn_occup;
                w_ro       = (OCC_WRITABLE == 0);
            end
            4'hC: w_region = c_rgn_tx_ctrl;
            4'hD: begin
                w_region   = c_rgn_flush;
                w_base_lo  = 2'd1;
            end
            default: w_mapped = 1'b0;
        endcase
        // Any address bit above bit 3 set means the access is outside the map.
        if ((haddr >> 4) != '0) begin
            w_mapped = 1'b0;
        end
    end

    always_comb begin
        w_nbytes = 3'd4;
        w_mask   = 4'b1111;
        case (hsize[1:0])
            2'd0: begin
                w_nbytes = 3'd1;
                w_mask   = 4'b0001;
            end
            2'd1: begin
                w_nbytes = 3'd2;
                w_mask   = 4'b0011;
            end
            default: begin
                w_nbytes = 3'd4;
                w_mask   = 4'b1111;
            end
        endcase
    end

    assign w_size_bad = (hsize > HSIZE_W'(2));
    assign w_off      = haddr[1:0] - w_base_lo;
    assign w_end      = {2'b00, w_off} + {1'b0, w_nbytes};
    assign w_overrun  = (w_end > {1'b0, w_rgn_size});
    // Shifting in a 4-bit context drops lanes past byte 3.
    assign w_byte_en  = w_mask << w_off;

`ifdef ADDR_DECODER_ALIGN_CHECK_EN
    assign w_misalign = ((hsize[1:0] == 2'd1) && haddr[0]) ||
                        ((hsize[1:0] == 2'd2) && (haddr[1:0] != 2'd0));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err = ~w_mapped | w_size_bad | (hwrite & w_ro) | w_overrun | w_misalign;

    // ------------------------------------------------------------------
    // Error-response FSM (two-cycle AHB ERROR)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= ST_IDLE;
            r_hready <= 1'b1;
            r_hresp  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_err) begin
                        r_state  <= ST_ERR1;
                        r_hready <= 1'b0;
                        r_hresp  <= 1'b1;
                    end
                end
                ST_ERR1: begin
                    r_state  <= ST_ERR2;
                    r_hready <= 1'b1;
                    r_hresp  <= 1'b1;
                end
                ST_ERR2: begin
                    // A transfer accepted in ERR2 may itself be illegal.
                    if (w_accept && w_err) begin
                        r_state  <= ST_ERR1;
                        r_hready <= 1'b0;
                        r_hresp  <= 1'b1;
                    end else begin
                        r_state  <= ST_IDLE;
                        r_hready <= 1'b1;
                        r_hresp  <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_hready <= 1'b1;
                    r_hresp  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Data-phase decode registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dec_valid   <= 1'b0;
            dec_write   <= 1'b0;
            dec_region  <= c_rgn_none;
            dec_byte_en <= 4'b0000;
        end else if (w_accept && !w_err) begin
            dec_valid   <= 1'b1;
            dec_write   <= hwrite;
            dec_region  <= w_region;
            dec_byte_en <= w_byte_en;
        end else begin
            dec_valid   <= 1'b0;
            dec_write   <= 1'b0;
            dec_region  <= c_rgn_none;
            dec_byte_en <= 4'b0000;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_addr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_slave_addr_decoder
// Description : Directed self-checking bench for ahb_slave_addr_decoder.
//               Expected data-phase results are queued when a transfer is
//               driven and compared once the clock edge has produced them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_slave_addr_decoder;

    typedef struct packed {
        logic       v;
        logic       w;
        logic [2:0] r;
        logic [3:0] be;
        logic       hr;
        logic       hp;
    } exp_t;

    logic       clk;
    logic       n_rst;
    logic       hsel;
    logic [1:0] htrans;
    logic [3:0] haddr;
    logic [2:0] hsize;
    logic       hwrite;
    logic       hready;
    logic       hresp;
    logic       dec_valid;
    logic       dec_write;
    logic [2:0] dec_region;
    logic [3:0] dec_byte_en;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    ahb_slave_addr_decoder dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .hsel       (hsel),
        .htrans     (htrans),
        .haddr      (haddr),
        .hsize      (hsize),
        .hwrite     (hwrite),
        .hready     (hready),
        .hresp      (hresp),
        .dec_valid  (dec_valid),
        .dec_write  (dec_write),
        .dec_region (dec_region),
        .dec_byte_en(dec_byte_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive the address phase, queue the expected data-phase
    // result, clock it, then compare just after the edge.
    task automatic step(input string tag, input logic s, input logic [1:0] t,
                        input logic [3:0] a, input logic [2:0] sz, input logic wr,
                        input logic ev, input logic ew, input logic [2:0] er,
                        input logic [3:0] ebe, input logic ehr, input logic ehp);
        exp_t e;
        hsel   = s;
        htrans = t;
        haddr  = a;
        hsize  = sz;
        hwrite = wr;
        sb.push_back('{ev, ew, er, ebe, ehr, ehp});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".valid"},  {3'b0, dec_valid}, {3'b0, e.v});
            chk({tag, ".write"},  {3'b0, dec_write}, {3'b0, e.w});
            chk({tag, ".region"}, {1'b0, dec_region}, {1'b0, e.r});
            chk({tag, ".be"},     dec_byte_en, e.be);
            chk({tag, ".hready"}, {3'b0, hready}, {3'b0, e.hr});
            chk({tag, ".hresp"},  {3'b0, hresp},  {3'b0, e.hp});
        end
    endtask

    task automatic idle_step(input string tag, input logic ehr, input logic ehp);
        step(tag, 1'b0, 2'd0, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd7, 4'h0, ehr, ehp);
    endtask

    initial begin
        hsel   = 1'b0;
        htrans = 2'd0;
        haddr  = 4'h0;
        hsize  = 3'd0;
        hwrite = 1'b0;
        n_rst  = 1'b1;
        #1 n_rst = 1'b0;
        #2;
        chk("rst.hready", {3'b0, hready}, 4'h1);
        chk("rst.hresp",  {3'b0, hresp},  4'h0);
        chk("rst.valid",  {3'b0, dec_valid}, 4'h0);
        chk("rst.region", {1'b0, dec_region}, 4'h7);
        chk("rst.be",     dec_byte_en, 4'h0);
        #9 n_rst = 1'b1;
        @(posedge clk);
        #1;

        // Normal decodes, back-to-back
        step("wr_word_0", 1, 2'd2, 4'h0, 3'd2, 1, 1, 1, 3'd0, 4'b1111, 1, 0);
        step("rd_byte_5", 1, 2'd3, 4'h5, 3'd0, 0, 1, 0, 3'd1, 4'b0010, 1, 0);
        step("rd_half_6", 1, 2'd2, 4'h6, 3'd1, 0, 1, 0, 3'd2, 4'b0011, 1, 0);
        step("wr_byte_C", 1, 2'd2, 4'hC, 3'd0, 1, 1, 1, 3'd4, 4'b0001, 1, 0);
        step("rd_byte_8", 1, 2'd2, 4'h8, 3'd0, 0, 1, 0, 3'd3, 4'b0001, 1, 0);
        step("wr_byte_D", 1, 2'd3, 4'hD, 3'd0, 1, 1, 1, 3'd5, 4'b0001, 1, 0);
        step("wr_half_2", 1, 2'd2, 4'h2, 3'd1, 1, 1, 1, 3'd0, 4'b1100, 1, 0);

        // Not selected / IDLE / BUSY: no decode, OKAY
        step("idle_tr",   1, 2'd0, 4'h0, 3'd2, 0, 0, 0, 3'd7, 4'h0, 1, 0);
        step("busy_tr",   1, 2'd1, 4'h0, 3'd2, 0, 0, 0, 3'd7, 4'h0, 1, 0);
        step("no_hsel",   0, 2'd2, 4'h0, 3'd2, 0, 0, 0, 3'd7, 4'h0, 1, 0);

        // Write to RO STATUS with halfword at 0x4; a transfer offered in ERR1
        // must be ignored.
        step("err_wr4",   1, 2'd2, 4'h4, 3'd1, 1, 0, 0, 3'd7, 4'h0, 0, 1);
        step("in_err1",   1, 2'd2, 4'h0, 3'd2, 0, 0, 0, 3'd7, 4'h0, 1, 1);
        idle_step("err_wr4.end", 1, 0);

        // Unmapped 0xA
        step("err_rdA",   1, 2'd2, 4'hA, 3'd0, 0, 0, 0, 3'd7, 4'h0, 0, 1);
        idle_step("err_rdA.e2", 1, 1);
        idle_step("err_rdA.end", 1, 0);

        // Unmapped 0x9, then read 0xC during ERR2 overlaps return to IDLE
        step("err_rd9",   1, 2'd2, 4'h9, 3'd0, 0, 0, 0, 3'd7, 4'h0, 0, 1);
        idle_step("err_rd9.e2", 1, 1);
        chk("err2.hready_in", {3'b0, hready}, 4'h1);
        step("rd_C_err2", 1, 2'd2, 4'hC, 3'd0, 0, 1, 0, 3'd4, 4'b0001, 1, 0);

        // Other error causes
        step("err_hsz3",  1, 2'd2, 4'h0, 3'd3, 0, 0, 0, 3'd7, 4'h0, 0, 1);
        idle_step("err_hsz3.e2", 1, 1);
        step("err_half8", 1, 2'd2, 4'h8, 3'd1, 0, 0, 0, 3'd7, 4'h0, 0, 1);
        idle_step("err_half8.e2", 1, 1);
        step("err_wr8",   1, 2'd2, 4'h8, 3'd0, 1, 0, 0, 3'd7, 4'h0, 0, 1);
        idle_step("err_wr8.e2", 1, 1);
        step("err_wr5",   1, 2'd2, 4'h5, 3'd0, 1, 0, 0, 3'd7, 4'h0, 0, 1);
        idle_step("err_wr5.e2", 1, 1);
        step("err_word2", 1, 2'd2, 4'h2, 3'd2, 0, 0, 0, 3'd7, 4'h0, 0, 1);
        idle_step("err_word2.e2", 1, 1);
        idle_step("err_word2.end", 1, 0);

        // Misaligned halfword at 0x1
`ifdef ADDR_DECODER_ALIGN_CHECK_EN
        step("half_1",    1, 2'd2, 4'h1, 3'd1, 0, 0, 0, 3'd7, 4'h0, 0, 1);
        idle_step("half_1.e2", 1, 1);
        idle_step("half_1.end", 1, 0);
`else
        step("half_1",    1, 2'd2, 4'h1, 3'd1, 0, 1, 0, 3'd0, 4'b0110, 1, 0);
        idle_step("half_1.end", 1, 0);
`endif

        // Asynchronous reset while in ERR1
        step("rst_err",   1, 2'd2, 4'h4, 3'd1, 1, 0, 0, 3'd7, 4'h0, 0, 1);
        hsel   = 1'b0;
        htrans = 2'd0;
        n_rst  = 1'b0;
        #1;
        chk("arst.hready", {3'b0, hready}, 4'h1);
        chk("arst.hresp",  {3'b0, hresp},  4'h0);
        chk("arst.region", {1'b0, dec_region}, 4'h7);
        chk("arst.valid",  {3'b0, dec_valid}, 4'h0);
        #1 n_rst = 1'b1;
        step("post_rst",  1, 2'd2, 4'h0, 3'd2, 0, 1, 0, 3'd0, 4'b1111, 1, 0);
        idle_step("final", 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
